// File: rtl/addr_bus_arbiter_pkg.sv
// Shared definitions for the address bus arbiter: FSM states, requester
// indices and the address width.
`timescale 1ns/1ps
package addr_bus_arbiter_pkg;

  localparam int ADDR_W = 16;
  localparam int NREQ   = 3;

  // Requester bit positions in req/wr/gnt/done
  localparam int FETCH = 0;
  localparam int DATA  = 1;
  localparam int STACK = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/addr_bus_arbiter_rr_pick3.sv
// Three-way round-robin selector. The search starts at the requester after
// the one named by the one-hot 'last' and wraps; result is one-hot or zero.
`timescale 1ns/1ps
module rr_pick3
  import addr_bus_arbiter_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] last,
  output logic [NREQ-1:0] pick
);

  // Rotate priority according to the previously granted requester
  always_comb begin
    pick = '0;
    if (last[FETCH]) begin
      if (req[DATA])        pick[DATA]  = 1'b1;
      else if (req[STACK])  pick[STACK] = 1'b1;
      else if (req[FETCH])  pick[FETCH] = 1'b1;
    end else if (last[DATA]) begin
      if (req[STACK])       pick[STACK] = 1'b1;
      else if (req[FETCH])  pick[FETCH] = 1'b1;
      else if (req[DATA])   pick[DATA]  = 1'b1;
    end else begin
      if (req[FETCH])       pick[FETCH] = 1'b1;
      else if (req[DATA])   pick[DATA]  = 1'b1;
      else if (req[STACK])  pick[STACK] = 1'b1;
    end
  end

endmodule

// File: rtl/addr_bus_arbiter.sv
// Address bus arbiter: grants one of fetch/data/stack round-robin, drives the
// external address latch (lat_addr/lat_en) and runs one bus cycle with a
// programmable minimum number of wait states before sampling mem_rdy.
`timescale 1ns/1ps
module addr_bus_arbiter
  import addr_bus_arbiter_pkg::*;
#(
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [ADDR_W-1:0] addr_f,
  input  logic [ADDR_W-1:0] addr_d,
  input  logic [ADDR_W-1:0] addr_s,
  input  logic [NREQ-1:0]   wr,
  input  logic              mem_rdy,
  output logic [ADDR_W-1:0] lat_addr,
  output logic              lat_en,
  output logic              bus_rd,
  output logic              bus_wr,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic              busy
);

  state_t              state;
  state_t              state_nxt;
  logic [3:0]          wcnt;
  logic [NREQ-1:0]     last;
  logic [NREQ-1:0]     pick;
  logic                wr_q;
  logic                grant_now;
  logic [ADDR_W-1:0]   addr_pick;

  rr_pick3 u_pick (
    .req  (req),
    .last (last),
    .pick (pick)
  );

  // Address of the winning requester (pick is one-hot or zero)
  always_comb begin
    addr_pick = ({ADDR_W{pick[FETCH]}} & addr_f)
              | ({ADDR_W{pick[DATA]}}  & addr_d)
              | ({ADDR_W{pick[STACK]}} & addr_s);
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic and state-decoded strobes
  always_comb begin
    state_nxt = state;
    grant_now = 1'b0;
    lat_en    = 1'b0;
    bus_rd    = 1'b0;
    bus_wr    = 1'b0;
    done      = '0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (|req) begin
          grant_now = 1'b1;
          state_nxt = LATCH;
        end
      end
      LATCH: begin
        lat_en    = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        bus_rd = ~wr_q;
        bus_wr = wr_q;
        if ((wcnt == 4'd0) && mem_rdy) state_nxt = DONE;
      end
      DONE: begin
        done      = gnt;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grant, latched address and write flag are captured once at grant time;
  // the grant is released as the cycle leaves DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt      <= '0;
      lat_addr <= '0;
      wr_q     <= 1'b0;
    end else if (grant_now) begin
      gnt      <= pick;
      lat_addr <= addr_pick;
      wr_q     <= |(wr & pick);
    end else if (state == DONE) begin
      gnt      <= '0;
    end
  end

  // Wait-state counter: loaded in LATCH, counts down to zero in WAIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt <= 4'd0;
    end else if (state == LATCH) begin
      wcnt <= 4'(WAIT_STATES);
    end else if ((state == WAIT) && (wcnt != 4'd0)) begin
      wcnt <= wcnt - 4'd1;
    end
  end

  // Last-granted pointer only moves on a completed cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              last <= 3'b100;
    else if (state == DONE)  last <= gnt;
  end

endmodule

// File: tb/tb_addr_bus_arbiter.sv
// Bench for addr_bus_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level reference model.
`timescale 1ns/1ps
module tb_addr_bus_arbiter;
  import addr_bus_arbiter_pkg::*;

  localparam int WS = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  req = '0;
  logic [2:0]  wr = '0;
  logic [15:0] addr_f = '0, addr_d = '0, addr_s = '0;
  logic        mem_rdy = 1'b0;

  logic [15:0] lat_addr, lat_addr0;
  logic        lat_en, bus_rd, bus_wr, busy;
  logic        lat_en0, bus_rd0, bus_wr0, busy0;
  logic [2:0]  gnt, done, gnt0, done0;

  int n_cmp = 0;
  int n_fail = 0;

  // reference model state
  int          m_ph;     // 0 idle, 1 latch, 2 wait, 3 done
  int          m_g;
  int          m_k;
  int          m_last;
  logic [15:0] m_addr;
  logic        m_wr;

  always #5 clk = ~clk;

  addr_bus_arbiter #(.WAIT_STATES(WS)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .addr_f(addr_f), .addr_d(addr_d),
    .addr_s(addr_s), .wr(wr), .mem_rdy(mem_rdy), .lat_addr(lat_addr),
    .lat_en(lat_en), .bus_rd(bus_rd), .bus_wr(bus_wr), .gnt(gnt),
    .done(done), .busy(busy)
  );

  addr_bus_arbiter #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req), .addr_f(addr_f), .addr_d(addr_d),
    .addr_s(addr_s), .wr(wr), .mem_rdy(mem_rdy), .lat_addr(lat_addr0),
    .lat_en(lat_en0), .bus_rd(bus_rd0), .bus_wr(bus_wr0), .gnt(gnt0),
    .done(done0), .busy(busy0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0; wr = '0; mem_rdy = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    m_ph = 0; m_g = 0; m_k = 0; m_last = 2; m_addr = '0; m_wr = 1'b0;
  endtask

  // Advance the model by one clock using the inputs about to be sampled
  task automatic mdl_step();
    logic [15:0] a [3];
    int c;
    bit found;
    a[0] = addr_f; a[1] = addr_d; a[2] = addr_s;
    found = 1'b0;
    case (m_ph)
      0: if (req != 3'b000) begin
           for (int i = 1; i <= 3; i++) begin
             c = (m_last + i) % 3;
             if (!found && req[c]) begin m_g = c; found = 1'b1; end
           end
           m_addr = a[m_g];
           m_wr   = wr[m_g];
           m_ph   = 1;
         end
      1: begin m_ph = 2; m_k = 0; end
      2: if (m_k >= WS && mem_rdy) m_ph = 3; else m_k++;
      default: begin m_last = m_g; m_ph = 0; end
    endcase
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 3'b111; mem_rdy = 1'b1; addr_f = 16'hFFFF;
    tick(); tick();
    n_cmp++;
    if ({gnt, done, lat_en, bus_rd, bus_wr, busy} !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b required 0", {gnt, done, lat_en, bus_rd, bus_wr, busy});
    end
    n_cmp++;
    if (lat_addr !== 16'h0000) begin
      n_fail++; $display("FAIL reset_lat_addr: got %h required 0000", lat_addr);
    end
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (gnt !== 3'b001) begin
      n_fail++; $display("FAIL reset_first_winner: got %b required 001", gnt);
    end
    req = '0;
    do_reset();
  endtask

  task automatic test_basic_read();
    logic [2:0] e_gnt, e_done;
    logic       e_lat, e_rd;
    do_reset();
    req = 3'b001; addr_f = 16'h1234; wr = 3'b000; mem_rdy = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      e_gnt  = (c <= 5) ? 3'b001 : 3'b000;
      e_lat  = (c == 1);
      e_rd   = (c >= 2 && c <= 4);
      e_done = (c == 5) ? 3'b001 : 3'b000;
      n_cmp++;
      if ({gnt, lat_en, bus_rd, bus_wr, done} !== {e_gnt, e_lat, e_rd, 1'b0, e_done}) begin
        n_fail++;
        $display("FAIL basic_clk%0d: got gnt=%b lat_en=%b rd=%b wr=%b done=%b required gnt=%b lat_en=%b rd=%b wr=0 done=%b",
                 c, gnt, lat_en, bus_rd, bus_wr, done, e_gnt, e_lat, e_rd, e_done);
      end
      n_cmp++;
      if (lat_addr !== 16'h1234) begin
        n_fail++; $display("FAIL basic_lat_addr_clk%0d: got %h required 1234", c, lat_addr);
      end
    end
    req = '0;
  endtask

  task automatic test_round_robin();
    logic [2:0] seen [$];
    logic [2:0] exp_seq [6];
    exp_seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    do_reset();
    req = 3'b111; wr = 3'b000; mem_rdy = 1'b1;
    for (int n = 0; n < 80 && seen.size() < 6; n++) begin
      tick();
      if (lat_en) seen.push_back(gnt);
    end
    req = '0;
    n_cmp++;
    if (seen.size() != 6) begin
      n_fail++; $display("FAIL rr_grant_count: got %0d required 6", seen.size());
    end
    for (int i = 0; i < seen.size() && i < 6; i++) begin
      n_cmp++;
      if (seen[i] !== exp_seq[i]) begin
        n_fail++; $display("FAIL rr_order_%0d: got %b required %b", i, seen[i], exp_seq[i]);
      end
    end
  endtask

  task automatic test_wait_extend();
    do_reset();
    req = 3'b010; wr = 3'b010; addr_d = 16'hA5A5; mem_rdy = 1'b0;
    tick();
    n_cmp++;
    if ({lat_en, gnt} !== 4'b1010) begin
      n_fail++; $display("FAIL wait_latch: got lat_en=%b gnt=%b required 1 010", lat_en, gnt);
    end
    req = '0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      n_cmp++;
      if ({bus_wr, bus_rd, done} !== 5'b10000) begin
        n_fail++;
        $display("FAIL wait_cycle%0d: got wr=%b rd=%b done=%b required wr=1 rd=0 done=000", k, bus_wr, bus_rd, done);
      end
      if (k == 5) mem_rdy = 1'b1;
    end
    tick();
    n_cmp++;
    if ({done, bus_wr, bus_rd} !== 5'b01000) begin
      n_fail++; $display("FAIL wait_done: got done=%b wr=%b rd=%b required 010 0 0", done, bus_wr, bus_rd);
    end
    tick();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL wait_idle_busy: got %b required 0", busy);
    end
    mem_rdy = 1'b0;
  endtask

  task automatic test_drop_req();
    do_reset();
    req = 3'b010; wr = 3'b010; addr_d = 16'hBEEF; mem_rdy = 1'b1;
    tick(); tick();
    req = '0; wr = '0; addr_d = 16'h0000;
    tick();
    n_cmp++;
    if ({bus_wr, bus_rd} !== 2'b10) begin
      n_fail++; $display("FAIL drop_strobe: got wr=%b rd=%b required 1 0", bus_wr, bus_rd);
    end
    tick(); tick();
    n_cmp++;
    if (done !== 3'b010) begin
      n_fail++; $display("FAIL drop_done: got %b required 010", done);
    end
    n_cmp++;
    if (lat_addr !== 16'hBEEF) begin
      n_fail++; $display("FAIL drop_lat_addr: got %h required beef", lat_addr);
    end
  endtask

  task automatic test_async_reset();
    logic [2:0] seen_done;
    do_reset();
    req = 3'b001; addr_f = 16'h5555; wr = '0; mem_rdy = 1'b1;
    tick(); tick();
    n_cmp++;
    if (bus_rd !== 1'b1) begin
      n_fail++; $display("FAIL areset_pre_wait: got rd=%b required 1", bus_rd);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({gnt, done, lat_en, bus_rd, bus_wr, busy} !== 10'b0) begin
      n_fail++;
      $display("FAIL areset_clear: got %b required 0", {gnt, done, lat_en, bus_rd, bus_wr, busy});
    end
    seen_done = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      seen_done |= done;
    end
    n_cmp++;
    if (seen_done !== 3'b000) begin
      n_fail++; $display("FAIL areset_no_done: got %b required 000", seen_done);
    end
    req = 3'b100;
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (gnt !== 3'b100) begin
      n_fail++; $display("FAIL areset_stack_first: got %b required 100", gnt);
    end
    do_reset();
    req = 3'b110;
    tick();
    n_cmp++;
    if (gnt !== 3'b010) begin
      n_fail++; $display("FAIL areset_ptr_bit2: got %b required 010", gnt);
    end
    req = '0;
  endtask

  task automatic test_min_cycle();
    do_reset();
    req = 3'b001; wr = '0; mem_rdy = 1'b1;
    tick();
    req = '0;
    n_cmp++;
    if ({lat_en0, gnt0} !== 4'b1001) begin
      n_fail++; $display("FAIL min_latch: got lat_en=%b gnt=%b required 1 001", lat_en0, gnt0);
    end
    tick();
    n_cmp++;
    if ({bus_rd0, done0} !== 4'b1000) begin
      n_fail++; $display("FAIL min_wait: got rd=%b done=%b required 1 000", bus_rd0, done0);
    end
    tick();
    n_cmp++;
    if (done0 !== 3'b001) begin
      n_fail++; $display("FAIL min_done: got %b required 001", done0);
    end
    tick();
    n_cmp++;
    if (busy0 !== 1'b0) begin
      n_fail++; $display("FAIL min_idle: got busy=%b required 0", busy0);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    req = 3'b011; wr = '0; mem_rdy = 1'b1;
    for (int c = 1; c <= 5; c++) tick();
    n_cmp++;
    if (done !== 3'b001) begin
      n_fail++; $display("FAIL b2b_first_done: got %b required 001", done);
    end
    tick();
    n_cmp++;
    if ({busy, gnt} !== 4'b0000) begin
      n_fail++; $display("FAIL b2b_idle_gap: got busy=%b gnt=%b required 0 000", busy, gnt);
    end
    tick();
    n_cmp++;
    if ({lat_en, gnt} !== 4'b1010) begin
      n_fail++; $display("FAIL b2b_second_grant: got lat_en=%b gnt=%b required 1 010", lat_en, gnt);
    end
    req = '0;
    for (int c = 0; c < 6; c++) tick();
  endtask

  task automatic test_random();
    logic [2:0]  e_gnt, e_done;
    logic [26:0] obs, exp_v;
    int          r;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 3);
      req     = (r == 0) ? 3'b000 : 3'($urandom_range(1, 7));
      wr      = 3'($urandom);
      addr_f  = 16'($urandom);
      addr_d  = 16'($urandom);
      addr_s  = 16'($urandom);
      mem_rdy = ($urandom_range(0, 2) != 0);
      mdl_step();
      tick();
      e_gnt  = (m_ph != 0) ? 3'(1 << m_g) : 3'b000;
      e_done = (m_ph == 3) ? 3'(1 << m_g) : 3'b000;
      exp_v = {e_gnt, e_done, (m_ph == 1), (m_ph == 2) && !m_wr, (m_ph == 2) && m_wr,
               (m_ph != 0), m_addr};
      obs   = {gnt, done, lat_en, bus_rd, bus_wr, busy, lat_addr};
      n_cmp++;
      if (obs !== exp_v) begin
        n_fail++; $display("FAIL random_cyc%0d: got %h required %h", n, obs, exp_v);
      end
      n_cmp++;
      if (bus_rd && bus_wr) begin
        n_fail++; $display("FAIL random_strobes_cyc%0d: got rd=1 wr=1 required not both", n);
      end
    end
    req = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic_read();
    test_round_robin();
    test_wait_extend();
    test_drop_req();
    test_async_reset();
    test_min_cycle();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
